pat_tx: RTL and testbench

- Serial pattern transmitter; the driving end of the single-bit `a` level interface consumed by the team's `a`-sequence detector FSMs.
- Captures a parallel pattern and a repeat count, then shifts the pattern out MSB-first, one bit per mclk, with a valid qualifier.
- Used as the stimulus source or on-chip pattern generator feeding detector blocks in the cell library.

---
 rtl/pat_pkg.sv | 30 +++
 rtl/pat_tx_if.sv | 28 ++
 rtl/pat_shreg.sv | 34 +++
 rtl/pat_tx.sv | 157 +++++++++++++++
 tb/tb_pat_tx.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pat_pkg.sv
// Shared definitions for the serial pattern transmitter.
// Holds the 4-bit state encodings used across the detector/transmitter family,
// the default widths, the registered-output bundle type and a small state helper.
package pat_pkg;

    localparam int PAT_W_DEF   = 8;
    localparam int CNT_W_DEF   = 4;
    localparam int GAP_LEN_DEF = 1;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'd1;
    localparam state_t ST_SHIFT = 4'd2;
    localparam state_t ST_GAP   = 4'd3;
    localparam state_t ST_DONE  = 4'd4;

    // Output bundle, kept together so all four outputs come from one register.
    typedef struct packed {
        logic a_out;
        logic a_vld;
        logic busy;
        logic done;
    } pat_out_t;

    // True for the states in which a transfer is in progress.
    function automatic logic st_active(input state_t st);
        return (st == ST_SHIFT) || (st == ST_GAP);
    endfunction

endpackage

// File: rtl/pat_tx_if.sv
// Pattern transmitter bus.
// master: drives start/abort/pat_in/rpt_in and observes the serial side.
// slave : the transmitter; receives the request, drives a_out/a_vld/busy/done.
interface pat_tx_if
    import pat_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] rpt_in;
    logic             a_out;
    logic             a_vld;
    logic             busy;
    logic             done;

    modport master (
        output start, abort, pat_in, rpt_in,
        input  a_out, a_vld, busy, done
    );

    modport slave (
        input  start, abort, pat_in, rpt_in,
        output a_out, a_vld, busy, done
    );
endinterface

// File: rtl/pat_shreg.sv
// Rotate-left pattern register.
// Ports: clk, rst (sync, active-high), load (capture din), shift_en (rotate by 1),
//        din (pattern), msb (current top bit), nxt_bit (bit that becomes msb after a rotate).
// Rotating rather than shifting keeps the pattern intact for repetitions.
module pat_shreg #(
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [PAT_W-1:0] din,
    output logic             msb,
    output logic             nxt_bit
);
    logic [PAT_W-1:0] shreg_r;

    // Pattern storage: load has priority over rotation.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_r <= {PAT_W{1'b0}};
        end else if (load) begin
            shreg_r <= din;
        end else if (shift_en) begin
            shreg_r <= {shreg_r[PAT_W-2:0], shreg_r[PAT_W-1]};
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign msb     = shreg_r[PAT_W-1];
    assign nxt_bit = shreg_r[PAT_W-2];

endmodule

// File: rtl/pat_tx.sv
// Serial pattern transmitter: captures a pattern and repeat count on start,
// shifts the pattern out MSB-first with a valid qualifier, optionally separated
// by GAP_LEN idle cycles between repetitions, then pulses done.
// Ports: mclk (clock), mreset (sync, active-high), bus (pat_tx_if.slave:
//        start, abort, pat_in, rpt_in in; a_out, a_vld, busy, done out).
// All outputs are registered from the next-state decode, so they change only
// on mclk and line up with the state the FSM is entering.
module pat_tx
    import pat_pkg::*;
#(
    parameter int PAT_W   = PAT_W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int GAP_LEN = GAP_LEN_DEF
) (
    input  logic mclk,
    input  logic mreset,
    pat_tx_if.slave bus
);
    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1'b1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1'b1);
    // With GAP_LEN=0 the GAP state is never entered, so this value is unused.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    state_t           state_r, state_s;
    logic [BIT_W-1:0] bit_cnt_r, bit_cnt_s;
    logic [CNT_W-1:0] rpt_cnt_r, rpt_cnt_s;
    logic [GAP_W-1:0] gap_cnt_r, gap_cnt_s;
    logic             load_s, shift_s;
    logic             msb_s, nxt_bit_s;
    pat_out_t         out_s, out_r;

    pat_shreg #(.PAT_W(PAT_W)) u_shreg (
        .clk      (mclk),
        .rst      (mreset),
        .load     (load_s),
        .shift_en (shift_s),
        .din      (bus.pat_in),
        .msb      (msb_s),
        .nxt_bit  (nxt_bit_s)
    );

    // Next-state and counter logic; abort beats normal progress in SHIFT/GAP.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        rpt_cnt_s = rpt_cnt_r;
        gap_cnt_s = gap_cnt_r;
        load_s    = 1'b0;
        shift_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    load_s    = 1'b1;
                    rpt_cnt_s = bus.rpt_in;
                    bit_cnt_s = BIT_ZERO;
                    gap_cnt_s = GAP_ZERO;
                    state_s   = ST_SHIFT;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else begin
                    shift_s = 1'b1;
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_s = BIT_ZERO;
                        if (rpt_cnt_r != CNT_ZERO) begin
                            rpt_cnt_s = rpt_cnt_r - CNT_ONE;
                            gap_cnt_s = GAP_ZERO;
                            // Without a gap the next repetition follows immediately.
                            if (GAP_LEN > 0) begin
                                state_s = ST_GAP;
                            end else begin
                                state_s = ST_SHIFT;
                            end
                        end else begin
                            state_s = ST_DONE;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + BIT_ONE;
                    end
                end
            end
            ST_GAP: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                end else if (gap_cnt_r == GAP_LAST) begin
                    state_s = ST_SHIFT;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s   = ST_IDLE;
                bit_cnt_s = BIT_ZERO;
                rpt_cnt_s = CNT_ZERO;
                gap_cnt_s = GAP_ZERO;
            end
        endcase
    end

    // Output decode of the state being entered; a_out tracks the register's next msb.
    always_comb begin
        out_s      = pat_out_t'(4'b0000);
        out_s.busy = st_active(state_s);
        if (state_s == ST_SHIFT) begin
            out_s.a_vld = 1'b1;
            if (load_s) begin
                out_s.a_out = bus.pat_in[PAT_W-1];
            end else if (shift_s) begin
                out_s.a_out = nxt_bit_s;
            end else begin
                out_s.a_out = msb_s;
            end
        end else if (state_s == ST_DONE) begin
            out_s.done = 1'b1;
        end else begin
            out_s.a_vld = 1'b0;
        end
    end

    // State, counters and output register with synchronous reset.
    always_ff @(posedge mclk) begin
        if (mreset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= BIT_ZERO;
            rpt_cnt_r <= CNT_ZERO;
            gap_cnt_r <= GAP_ZERO;
            out_r     <= pat_out_t'(4'b0000);
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            rpt_cnt_r <= rpt_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            out_r     <= out_s;
        end
    end

    assign bus.a_out = out_r.a_out;
    assign bus.a_vld = out_r.a_vld;
    assign bus.busy  = out_r.busy;
    assign bus.done  = out_r.done;

endmodule

// File: tb/tb_pat_tx.sv
// Self-checking bench for pat_tx. Two instances share the stimulus: one with
// GAP_LEN=1 (index 0) and one with GAP_LEN=0 (index 1). A per-instance queue
// holds the expected {a_vld,a_out,busy,done} for every future cycle; it is
// filled when a start is driven and popped once per clock.
module tb_pat_tx;
    import pat_pkg::*;

    typedef struct packed {
        logic vld;
        logic out;
        logic busy;
        logic done;
    } exp_t;

    typedef struct {
        logic [7:0] pat;
        logic [3:0] rpt;
        int         busy_g1;
        int         busy_g0;
        string      name;
    } vec_t;

    logic       mclk = 1'b0;
    logic       mreset, start, abort;
    logic [7:0] pat;
    logic [3:0] rpt;

    always #5 mclk = ~mclk;

    pat_tx_if #(.PAT_W(8), .CNT_W(4)) bus_g1 ();
    pat_tx_if #(.PAT_W(8), .CNT_W(4)) bus_g0 ();

    assign bus_g1.start  = start;
    assign bus_g1.abort  = abort;
    assign bus_g1.pat_in = pat;
    assign bus_g1.rpt_in = rpt;
    assign bus_g0.start  = start;
    assign bus_g0.abort  = abort;
    assign bus_g0.pat_in = pat;
    assign bus_g0.rpt_in = rpt;

    pat_tx #(.PAT_W(8), .CNT_W(4), .GAP_LEN(1)) dut_g1 (.mclk(mclk), .mreset(mreset), .bus(bus_g1));
    pat_tx #(.PAT_W(8), .CNT_W(4), .GAP_LEN(0)) dut_g0 (.mclk(mclk), .mreset(mreset), .bus(bus_g0));

    logic [3:0] obs [2];
    assign obs[0] = {bus_g1.a_vld, bus_g1.a_out, bus_g1.busy, bus_g1.done};
    assign obs[1] = {bus_g0.a_vld, bus_g0.a_out, bus_g0.busy, bus_g0.done};

    exp_t q [2][$];
    exp_t cur [2];
    int   checks   = 0;
    int   failures = 0;
    int   busy_n [2];
    int   done_n [2];
    vec_t tbl [6];

    function automatic int gap_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic exp_t mk(input logic v, input logic o, input logic b, input logic d);
        exp_t e;
        e.vld = v; e.out = o; e.busy = b; e.done = d;
        return e;
    endfunction

    // Expected cycle-by-cycle trace of one accepted start.
    task automatic push_xfer(input int i, input logic [7:0] p, input logic [3:0] r);
        for (int k = 0; k <= int'(r); k++) begin
            for (int b = 7; b >= 0; b--) q[i].push_back(mk(1'b1, p[b], 1'b1, 1'b0));
            if (k < int'(r)) begin
                for (int g = 0; g < gap_of(i); g++) q[i].push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
            end
        end
        q[i].push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One clock: update the model from the inputs about to be sampled, then compare.
    task automatic cycle();
        exp_t       e;
        logic [3:0] ev;
        for (int i = 0; i < 2; i++) begin
            if (mreset) q[i].delete();
            else if (cur[i].busy && abort) q[i].delete();
            else if (!cur[i].busy && !cur[i].done && start) push_xfer(i, pat, rpt);
        end
        @(posedge mclk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (q[i].size() > 0) e = q[i].pop_front();
            else e = mk(1'b0, 1'b0, 1'b0, 1'b0);
            cur[i] = e;
            ev = e;
            checks++;
            if (obs[i] !== ev) begin
                failures++;
                $display("FAIL out_gap%0d t=%0t vld/out/busy/done got=%b exp=%b",
                         gap_of(i), $time, obs[i], ev);
            end
            busy_n[i] += int'(obs[i][1]);
            done_n[i] += int'(obs[i][0]);
        end
    endtask

    function automatic logic model_idle();
        return (q[0].size() == 0) && (q[1].size() == 0) &&
               (cur[0] == 4'b0000) && (cur[1] == 4'b0000);
    endfunction

    task automatic run_idle(input string name, input int max);
        int n;
        n = 0;
        while (!model_idle() && n < max) begin
            cycle();
            n++;
        end
        if (!model_idle()) begin
            checks++;
            failures++;
            $display("FAIL %s timeout got=%0d cycles exp<%0d", name, n, max);
        end
    endtask

    task automatic clr_counts();
        for (int i = 0; i < 2; i++) begin
            busy_n[i] = 0;
            done_n[i] = 0;
        end
    endtask

    task automatic one_xfer(input string name, input logic [7:0] p, input logic [3:0] r,
                            input int b1, input int b0);
        clr_counts();
        pat = p; rpt = r; start = 1'b1;
        cycle();
        start = 1'b0;
        run_idle(name, 300);
        check_int({name, "_busy_gap1"}, busy_n[0], b1);
        check_int({name, "_busy_gap0"}, busy_n[1], b0);
        check_int({name, "_done_gap1"}, done_n[0], 1);
        check_int({name, "_done_gap0"}, done_n[1], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mreset = 1'b1; start = 1'b0; abort = 1'b0; pat = 8'h00; rpt = 4'd0;
        cur[0] = mk(1'b0, 1'b0, 1'b0, 1'b0);
        cur[1] = mk(1'b0, 1'b0, 1'b0, 1'b0);
        clr_counts();

        // busy cycles = (rpt+1)*8 + rpt*GAP_LEN
        tbl[0] = '{8'hA5, 4'd0,   8,   8, "single_a5"};
        tbl[1] = '{8'hF0, 4'd2,  26,  24, "rpt_gap_f0"};
        tbl[2] = '{8'h81, 4'd1,  17,  16, "b2b_81"};
        tbl[3] = '{8'h3C, 4'd3,  35,  32, "rpt3_3c"};
        tbl[4] = '{8'h01, 4'd15, 143, 128, "max_rpt"};
        tbl[5] = '{8'h00, 4'd0,   8,   8, "zero_pat"};

        repeat (3) cycle();
        mreset = 1'b0;
        cycle();

        for (int t = 0; t < 6; t++) begin
            one_xfer(tbl[t].name, tbl[t].pat, tbl[t].rpt, tbl[t].busy_g1, tbl[t].busy_g0);
        end

        // Reset held for three cycles in the middle of a transfer.
        pat = 8'hA5; rpt = 4'd3; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        mreset = 1'b1;
        repeat (3) cycle();
        mreset = 1'b0;
        cycle();
        one_xfer("after_reset", 8'h5A, 4'd1, 17, 16);

        // Abort during the 4th bit, then start (with abort also high) two cycles later.
        clr_counts();
        pat = 8'hC3; rpt = 4'd2; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        cycle();
        check_int("abort_no_done_gap1", done_n[0], 0);
        check_int("abort_no_done_gap0", done_n[1], 0);
        abort = 1'b1; start = 1'b1; pat = 8'h96; rpt = 4'd0;
        cycle();
        abort = 1'b0; start = 1'b0;
        run_idle("abort_restart", 100);
        check_int("abort_restart_done_gap1", done_n[0], 1);

        // Abort landing in the gap cycle of the GAP_LEN=1 instance.
        clr_counts();
        pat = 8'hF0; rpt = 4'd1; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (8) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        run_idle("abort_gap", 50);
        check_int("abort_gap_done_gap1", done_n[0], 0);
        check_int("abort_gap_done_gap0", done_n[1], 0);

        // Start held through a transfer and DONE; inputs change mid-transfer.
        clr_counts();
        pat = 8'h3C; rpt = 4'd1; start = 1'b1;
        cycle();
        pat = 8'hE7; rpt = 4'd2;
        repeat (21) cycle();
        start = 1'b0;
        run_idle("held_start", 200);
        check_int("held_busy_gap1", busy_n[0], 17 + 26);
        check_int("held_busy_gap0", busy_n[1], 16 + 24);
        check_int("held_done_gap1", done_n[0], 2);
        check_int("held_done_gap0", done_n[1], 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
